part_5_operand_loader: RTL and testbench

- Byte-serial front end for the 32-bit adder stage (`part_4_top_module`).
- Accepts operand bytes over an 8-bit valid/ready stream and assembles operands a and b, each little-endian.
- Presents a and b to the adder with an op_valid/op_ready handshake and holds them until the downstream stage accepts.

---
 rtl/part_5_operand_loader_pkg.sv | 18 +
 rtl/part_5_byte_assembler.sv | 46 ++++
 rtl/part_5_operand_loader.sv | 157 +++++++++++++++
 tb/tb_part_5_operand_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/part_5_operand_loader_pkg.sv
// Shared definitions for the byte-serial operand loader: FSM encodings and byte width.
package part_5_operand_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_HOLD   = 2'd2,
    ST_CHK    = 2'd3
  } state_e;

  // Byte index width; a single-byte operand still needs a 1-bit counter.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/part_5_byte_assembler.sv
// Builds a DATA_W operand one byte at a time: byte lane idx receives din when wr_en is high.
module part_5_byte_assembler
  import part_5_operand_loader_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NBYTES = DATA_W / BYTE_W,
  parameter int CNT_W  = cnt_width(DATA_W / BYTE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [CNT_W-1:0]  idx,
  input  logic [BYTE_W-1:0] din,
  output logic [DATA_W-1:0] q
);

  genvar gi;
  generate
    for (gi = 0; gi < NBYTES; gi++) begin : g_lane
      logic [BYTE_W-1:0] lane_q;
      logic [BYTE_W-1:0] lane_d;

      // Clear wins over a write so an abort never leaves stale bytes behind.
      always_comb begin
        lane_d = lane_q;
        if (clr) begin
          lane_d = '0;
        end else if (wr_en && (idx == CNT_W'(gi))) begin
          lane_d = din;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lane_q <= '0;
        end else begin
          lane_q <= lane_d;
        end
      end

      assign q[gi*BYTE_W +: BYTE_W] = lane_q;
    end
  endgenerate

endmodule

// File: rtl/part_5_operand_loader.sv
// Byte-serial front end: assembles little-endian operands a and b and hands them to the adder.
// Optional checksum byte after b is enabled by defining PART_5_CHK_EN.
module part_5_operand_loader
  import part_5_operand_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              err
);

  localparam int NBYTES = DATA_W / BYTE_W;
  localparam int CNT_W  = cnt_width(NBYTES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             last_byte;
  logic             wr_a, wr_b;

`ifdef PART_5_CHK_EN
  logic [7:0] xor_q, xor_d;
  logic       err_q, err_d;
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign accept    = in_valid & in_ready;
  assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_LOAD_A;
      cnt_q   <= '0;
`ifdef PART_5_CHK_EN
      xor_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
`ifdef PART_5_CHK_EN
      xor_q   <= xor_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_a    = 1'b0;
    wr_b    = 1'b0;
`ifdef PART_5_CHK_EN
    xor_d   = xor_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      ST_LOAD_A: begin
        if (accept) begin
          wr_a  = 1'b1;
          cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
          if (last_byte) state_d = ST_LOAD_B;
`ifdef PART_5_CHK_EN
          xor_d = xor_q ^ in_data;
`endif
        end
      end
      ST_LOAD_B: begin
        if (accept) begin
          wr_b  = 1'b1;
          cnt_d = last_byte ? '0 : cnt_q + CNT_W'(1);
`ifdef PART_5_CHK_EN
          xor_d = xor_q ^ in_data;
          if (last_byte) state_d = ST_CHK;
`else
          if (last_byte) state_d = ST_HOLD;
`endif
        end
      end
      ST_HOLD: begin
        if (op_ready) state_d = ST_LOAD_A;
      end
      ST_CHK: begin
`ifdef PART_5_CHK_EN
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = ST_HOLD;
          end else begin
            state_d = ST_LOAD_A;
            err_d   = 1'b1;
          end
        end
`else
        state_d = ST_LOAD_A;
`endif
      end
      default: state_d = ST_LOAD_A;
    endcase

`ifdef PART_5_CHK_EN
    // The running checksum restarts whenever a fresh transaction begins.
    if ((state_d == ST_LOAD_A) && (state_q != ST_LOAD_A)) xor_d = '0;
`endif

    if (clr) begin
      state_d = ST_LOAD_A;
      cnt_d   = '0;
      wr_a    = 1'b0;
      wr_b    = 1'b0;
`ifdef PART_5_CHK_EN
      xor_d   = '0;
      err_d   = 1'b0;
`endif
    end
  end

  always_comb begin
    in_ready = (state_q != ST_HOLD);
    op_valid = (state_q == ST_HOLD);
  end

  part_5_byte_assembler #(
    .DATA_W (DATA_W)
  ) u_asm_a (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .wr_en (wr_a),
    .idx   (cnt_q),
    .din   (in_data),
    .q     (a)
  );

  part_5_byte_assembler #(
    .DATA_W (DATA_W)
  ) u_asm_b (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .wr_en (wr_b),
    .idx   (cnt_q),
    .din   (in_data),
    .q     (b)
  );

endmodule

// File: tb/tb_part_5_operand_loader.sv
// Scoreboard bench for part_5_operand_loader: stimulus pushes expected operands, a monitor checks handshakes.
module tb_part_5_operand_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        op_valid;
  logic        op_ready = 1'b0;
  logic        err;

`ifdef PART_5_CHK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] ea;
    logic [31:0] eb;
  } txn_t;

  txn_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   rdy_mode = 0;  // 0: always ready, 1: random, 2: never
  int   txn_no = 0;

  part_5_operand_loader #(.DATA_W(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: op_ready = 1'b1;
        1: op_ready = 1'($urandom_range(0, 1));
        default: op_ready = 1'b0;
      endcase
    end
  end

  // Monitor: every completed op handshake must match the oldest expected operand pair.
  initial begin
    txn_t t;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("in_ready_vs_hold", {63'd0, in_ready}, {63'd0, ~op_valid});
        if (op_valid && op_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_op: got a=%08h b=%08h expected no transaction", a, b);
          end else begin
            t = exp_q.pop_front();
            txn_no++;
            $display("txn %0d: a=%08h b=%08h (expected a=%08h b=%08h)", txn_no, a, b, t.ea, t.eb);
            check("op_a", {32'd0, a}, {32'd0, t.ea});
            check("op_b", {32'd0, b}, {32'd0, t.eb});
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input int maxgap);
    int g;
    int w;
    g = (maxgap > 0) ? $urandom_range(0, maxgap) : 0;
    if (g > 0) begin
      in_valid = 1'b0;
      repeat (g) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    in_data  = d;
    w = 0;
    while (!in_ready && w < 300) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 300) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 for %0d cycles expected 1", w);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_txn(input logic [31:0] ta, input logic [31:0] tb_v, input int maxgap,
                          input bit push, input bit corrupt);
    logic [7:0] x;
    txn_t t;
    x = 8'h00;
    if (push) begin
      t.ea = ta;
      t.eb = tb_v;
      exp_q.push_back(t);
    end
    for (int k = 0; k < 4; k++) begin
      send_byte(ta[8*k +: 8], maxgap);
      x = x ^ ta[8*k +: 8];
    end
    for (int k = 0; k < 4; k++) begin
      send_byte(tb_v[8*k +: 8], maxgap);
      x = x ^ tb_v[8*k +: 8];
    end
    if (corrupt) x = ~x;
    if (CHK_ON) send_byte(x, maxgap);
  endtask

  initial begin
    int w;
    logic [31:0] ra, rb;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", {32'd0, a}, 64'd0);
    check("rst_b", {32'd0, b}, 64'd0);
    check("rst_op_valid", {63'd0, op_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_err", {63'd0, err}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Back-to-back bytes, downstream always ready.
    rdy_mode = 0;
    send_txn(32'h0000ffff, 32'h00000001, 0, 1'b1, 1'b0);
    check("t1_op_valid_on", {63'd0, op_valid}, 64'd1);
    check("t1_sum", {32'd0, a + b}, {32'd0, 32'h00010000});
    @(posedge clk);
    #1;
    check("t1_op_valid_off", {63'd0, op_valid}, 64'd0);

    // Downstream stalls for 5 cycles; outputs must hold and no byte may be taken.
    rdy_mode = 2;
    op_ready = 1'b0;
    send_txn(32'h0000ffff, 32'h0002ccc1, 0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 8'h5a;
      check("t2_hold_valid", {63'd0, op_valid}, 64'd1);
      check("t2_hold_a", {32'd0, a}, {32'd0, 32'h0000ffff});
      check("t2_hold_b", {32'd0, b}, {32'd0, 32'h0002ccc1});
      check("t2_in_ready", {63'd0, in_ready}, 64'd0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("t2_sum", {32'd0, a + b}, {32'd0, 32'h0003ccc0});
    rdy_mode = 0;
    op_ready = 1'b1;
    @(posedge clk);
    #1;
    check("t2_released", {63'd0, op_valid}, 64'd0);
    check("t2_back_to_load_a", {63'd0, in_ready}, 64'd1);

    // Random in_valid gaps.
    send_txn(32'h00000001, 32'h00000002, 3, 1'b1, 1'b0);
    check("t3_sum", {32'd0, a + b}, 64'd3);
    @(posedge clk);
    #1;

    // Abort after 5 bytes with clr.
    for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k), 0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check("clr_a", {32'd0, a}, 64'd0);
    check("clr_b", {32'd0, b}, 64'd0);
    check("clr_op_valid", {63'd0, op_valid}, 64'd0);
    send_txn(32'h00000000, 32'h00000001, 0, 1'b1, 1'b0);
    check("clr_next_valid", {63'd0, op_valid}, 64'd1);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of b.
    for (int k = 0; k < 6; k++) send_byte(8'hc0 + 8'(k), 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_a", {32'd0, a}, 64'd0);
    check("arst_b", {32'd0, b}, 64'd0);
    check("arst_op_valid", {63'd0, op_valid}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_txn(32'h12345678, 32'h9abcdef0, 0, 1'b1, 1'b0);
    @(posedge clk);
    #1;

`ifdef PART_5_CHK_EN
    // Corrupted checksum: one err pulse, no operands delivered, then a normal load.
    send_txn(32'hdeadbeef, 32'h01020304, 0, 1'b0, 1'b1);
    check("chk_err_pulse", {63'd0, err}, 64'd1);
    check("chk_no_valid", {63'd0, op_valid}, 64'd0);
    @(posedge clk);
    #1;
    check("chk_err_end", {63'd0, err}, 64'd0);
    check("chk_no_valid2", {63'd0, op_valid}, 64'd0);
    send_txn(32'hcafef00d, 32'h00ff00ff, 0, 1'b1, 1'b0);
    check("chk_ok_valid", {63'd0, op_valid}, 64'd1);
    check("chk_ok_err", {63'd0, err}, 64'd0);
    @(posedge clk);
    #1;
`endif

    // Randomised operands with random gaps and random downstream readiness.
    rdy_mode = 1;
    for (int n = 0; n < 20; n++) begin
      ra = $urandom();
      rb = $urandom();
      send_txn(ra, rb, 3, 1'b1, 1'b0);
    end
    rdy_mode = 0;

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      #1;
      w++;
    end
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
